// File: rtl/string_hw_pkg.sv
// Shared types, register offsets and enums for the String_HW CSR front-end.
package string_hw_pkg;

    localparam int MAX_BLOCKS = 2;
    localparam int STR_BYTES  = MAX_BLOCKS * 4;

    typedef logic [0:STR_BYTES-1][7:0] string_t;

    localparam int CTRL_ADDR = 0;
    localparam int CFG_ADDR  = 1;
    localparam int A_BASE    = 2;

    // Operand/result windows slide with the block count, so offsets are derived from it.
    function automatic int b_base(input int n_blocks);
        return A_BASE + n_blocks;
    endfunction

    function automatic int r_base(input int n_blocks);
        return A_BASE + 2 * n_blocks;
    endfunction

    localparam int B_BASE = b_base(MAX_BLOCKS);
    localparam int R_BASE = r_base(MAX_BLOCKS);

    typedef enum logic [3:0] {
        CMP     = 4'd0,
        UPPER   = 4'd1,
        LOWER   = 4'd2,
        REVERSE = 4'd3,
        SEARCH  = 4'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

endpackage

// File: rtl/string_hw_csr_if.sv
// Avalon-MM slave bus bundle used between the Nios II side and string_hw_csr.
interface string_hw_csr_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write;
    logic [31:0]       writedata;
    logic              read;
    logic [31:0]       readdata;

    modport master (
        output address, chipselect, write, writedata, read,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write, writedata, read,
        output readdata
    );
endinterface

// File: rtl/string_word_pack.sv
// Moves a 32-bit bus word in and out of its four byte slots of a packed string;
// byte 4k sits in bits [31:24] so string literals read naturally.
module string_word_pack #(
    parameter int N = 2
) (
    input  logic [0:N*4-1][7:0] str_i,
    input  logic [1:0]          word_idx_i,
    input  logic [31:0]         word_i,
    output logic [31:0]         word_o,
    output logic [0:N*4-1][7:0] str_o
);
    logic [31:0] words [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_word
        assign words[gi] = {str_i[4*gi], str_i[4*gi+1], str_i[4*gi+2], str_i[4*gi+3]};
    end

    always_comb begin
        word_o = '0;
        str_o  = str_i;
        for (int k = 0; k < N; k++) begin
            if (int'(word_idx_i) == k) begin
                word_o = words[k];
                for (int j = 0; j < 4; j++) begin
                    str_o[4*k+j] = word_i[31-8*j -: 8];
                end
            end
        end
    end
endmodule

// File: rtl/string_hw_csr.sv
// Register front-end driving the String_HW core's go/done handshake and capturing Result.
// Define STRING_HW_TIMEOUT_EN to build the RUN-state watchdog (CTRL bit3).
module string_hw_csr #(
    parameter int MAX_BLOCKS     = string_hw_pkg::MAX_BLOCKS,
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    string_hw_csr_if.slave               avs,
    output logic                         go,
    output logic [3:0]                   index,
    output logic [7:0]                   length,
    output logic [0:MAX_BLOCKS*4-1][7:0] A,
    output logic [0:MAX_BLOCKS*4-1][7:0] B,
    input  logic                         done,
    input  logic [0:MAX_BLOCKS*4-1][7:0] Result
);
    import string_hw_pkg::*;

    localparam int NB    = MAX_BLOCKS * 4;
    localparam int B_OFF = b_base(MAX_BLOCKS);
    localparam int R_OFF = r_base(MAX_BLOCKS);
    localparam int E_OFF = R_OFF + MAX_BLOCKS;

    typedef logic [0:NB-1][7:0] str_t;

    state_e      state_q;
    logic        go_q;
    logic [3:0]  index_q;
    logic [7:0]  length_q;
    str_t        a_q, b_q, r_q;
    logic        done_flag_q;
    logic        err_busy_q;
    logic [31:0] readdata_q;
    logic        err_timeout;

`ifdef STRING_HW_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_q;
    logic             err_timeout_q;
    logic             abort_q;
    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

    logic [ADDR_W-1:0] addr;
    int                addr_n;
    logic              sel_ctrl, sel_cfg, sel_a, sel_b, sel_r;
    logic [1:0]        word_idx;
    logic              wr_en, rd_en, busy;
    logic [31:0]       a_word, b_word, r_word, rd_word;
    str_t              a_wr, b_wr, r_wr_unused;

    assign addr     = avs.address;
    assign addr_n   = int'(addr);
    assign wr_en    = avs.chipselect & avs.write;
    assign rd_en    = avs.chipselect & avs.read;
    assign busy     = (state_q != ST_IDLE);
    assign sel_ctrl = (addr_n == CTRL_ADDR);
    assign sel_cfg  = (addr_n == CFG_ADDR);
    assign sel_a    = (addr_n >= A_BASE) && (addr_n < B_OFF);
    assign sel_b    = (addr_n >= B_OFF) && (addr_n < R_OFF);
    assign sel_r    = (addr_n >= R_OFF) && (addr_n < E_OFF);

    always_comb begin
        word_idx = '0;
        if (sel_a)      word_idx = 2'(addr_n - A_BASE);
        else if (sel_b) word_idx = 2'(addr_n - B_OFF);
        else if (sel_r) word_idx = 2'(addr_n - R_OFF);
    end

    string_word_pack #(.N(MAX_BLOCKS)) u_pack_a (
        .str_i(a_q), .word_idx_i(word_idx), .word_i(avs.writedata),
        .word_o(a_word), .str_o(a_wr)
    );

    string_word_pack #(.N(MAX_BLOCKS)) u_pack_b (
        .str_i(b_q), .word_idx_i(word_idx), .word_i(avs.writedata),
        .word_o(b_word), .str_o(b_wr)
    );

    // Result is read-only from the bus; only the extract half of this instance matters.
    string_word_pack #(.N(MAX_BLOCKS)) u_pack_r (
        .str_i(r_q), .word_idx_i(word_idx), .word_i(avs.writedata),
        .word_o(r_word), .str_o(r_wr_unused)
    );

    always_comb begin
        rd_word = '0;
        if (sel_ctrl)     rd_word = {28'b0, err_timeout, err_busy_q, done_flag_q, busy};
        else if (sel_cfg) rd_word = {16'b0, length_q, 4'b0, index_q};
        else if (sel_a)   rd_word = a_word;
        else if (sel_b)   rd_word = b_word;
        else if (sel_r)   rd_word = r_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_q <= '0;
        end else if (rd_en) begin
            readdata_q <= rd_word;
        end
    end

    assign avs.readdata = readdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            go_q        <= 1'b0;
            index_q     <= '0;
            length_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            r_q         <= '0;
            done_flag_q <= 1'b0;
            err_busy_q  <= 1'b0;
`ifdef STRING_HW_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            err_timeout_q <= 1'b0;
            abort_q       <= 1'b0;
`endif
        end else begin
            if (wr_en) begin
                if (sel_ctrl) begin
                    // CLR is handled before START so a combined write restarts cleanly.
                    if (avs.writedata[1]) begin
                        done_flag_q <= 1'b0;
                        err_busy_q  <= 1'b0;
`ifdef STRING_HW_TIMEOUT_EN
                        err_timeout_q <= 1'b0;
`endif
                    end
                    if (avs.writedata[0]) begin
                        if (busy) begin
                            err_busy_q <= 1'b1;
                        end else begin
                            state_q     <= ST_RUN;
                            go_q        <= 1'b1;
                            done_flag_q <= 1'b0;
`ifdef STRING_HW_TIMEOUT_EN
                            tmo_cnt_q <= '0;
                            abort_q   <= 1'b0;
`endif
                        end
                    end
                end else if (sel_cfg || sel_a || sel_b) begin
                    if (busy) begin
                        err_busy_q <= 1'b1;
                    end else if (sel_cfg) begin
                        index_q  <= avs.writedata[3:0];
                        length_q <= avs.writedata[15:8];
                    end else if (sel_a) begin
                        a_q <= a_wr;
                    end else begin
                        b_q <= b_wr;
                    end
                end
            end

            case (state_q)
                ST_IDLE: begin
                end
                ST_RUN: begin
                    if (done) begin
                        r_q     <= Result;
                        state_q <= ST_RELEASE;
                        go_q    <= 1'b0;
                    end
`ifdef STRING_HW_TIMEOUT_EN
                    else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q       <= ST_RELEASE;
                        go_q          <= 1'b0;
                        err_timeout_q <= 1'b1;
                        abort_q       <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
`endif
                end
                ST_RELEASE: begin
                    if (!done) begin
                        state_q <= ST_IDLE;
`ifdef STRING_HW_TIMEOUT_EN
                        if (!abort_q) done_flag_q <= 1'b1;
`else
                        done_flag_q <= 1'b1;
`endif
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    go_q    <= 1'b0;
                end
            endcase
        end
    end

    assign go     = go_q;
    assign index  = index_q;
    assign length = length_q;
    assign A      = a_q;
    assign B      = b_q;
endmodule

// File: tb/tb_string_hw_csr.sv
// Self-checking bench for string_hw_csr: register table, directed handshake corners,
// and randomized traffic against a word-level shadow of the register map plus a core model.
module tb_string_hw_csr;
    import string_hw_pkg::*;

    localparam int N   = 2;
    localparam int NB  = N * 4;
    localparam int TMO = 16;

    typedef logic [0:NB-1][7:0] str_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    string_hw_csr_if #(.ADDR_W(4)) avs ();

    logic       go;
    logic [3:0] index;
    logic [7:0] length;
    str_t       A, B, Result;
    logic       done;

    string_hw_csr #(.MAX_BLOCKS(N), .ADDR_W(4), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .avs(avs),
        .go(go), .index(index), .length(length),
        .A(A), .B(B), .done(done), .Result(Result)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural string operations the core is assumed to perform.
    function automatic str_t op_result(input logic [3:0] op, input logic [7:0] len,
                                       input str_t a, input str_t b);
        str_t r;
        bit   found;
        bit   hit;
        r = '0;
        case (op)
            4'd0: r[NB-1] = (a == b) ? 8'd0 : 8'd1;
            4'd1: for (int i = 0; i < NB; i++)
                      r[i] = (a[i] >= 8'h61 && a[i] <= 8'h7a) ? a[i] - 8'd32 : a[i];
            4'd2: for (int i = 0; i < NB; i++)
                      r[i] = (a[i] >= 8'h41 && a[i] <= 8'h5a) ? a[i] + 8'd32 : a[i];
            4'd3: for (int i = 0; i < NB; i++) r[i] = a[NB-1-i];
            4'd4: begin
                r[NB-1] = 8'hFF;
                found = 1'b0;
                for (int p = 0; p + int'(len) <= NB; p++) begin
                    hit = 1'b1;
                    for (int q = 0; q < int'(len); q++) if (a[p+q] != b[q]) hit = 1'b0;
                    if (hit && !found) begin
                        found = 1'b1;
                        r[NB-1] = 8'(p);
                    end
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Core model: answers core_delay cycles into go, holds done until go drops.
    int   core_delay;
    bit   core_never;
    bit   force_done;
    str_t pre_res;
    str_t core_res;
    logic core_done;
    int   core_cnt;

    always @(posedge clk) begin
        if (reset) begin
            core_done <= 1'b0;
            core_cnt  <= 0;
            core_res  <= '0;
        end else if (go) begin
            if (!core_never && !core_done) begin
                if (core_cnt >= core_delay) begin
                    core_done <= 1'b1;
                    core_res  <= op_result(index, length, A, B);
                end else begin
                    core_cnt <= core_cnt + 1;
                end
            end
        end else begin
            core_done <= 1'b0;
            core_cnt  <= 0;
        end
    end

    assign done   = core_done | force_done;
    assign Result = force_done ? pre_res : core_res;

    // Word-level shadow of the register map.
    logic [31:0] sa [N];
    logic [31:0] sb [N];
    logic [31:0] sr [N];
    logic [3:0]  s_index;
    logic [7:0]  s_len;
    bit          e_busy, e_done, e_errb, e_errt;
    str_t        pending_res;

    function automatic str_t w2s(input logic [31:0] w [N]);
        str_t s;
        for (int k = 0; k < N; k++)
            for (int j = 0; j < 4; j++) s[4*k+j] = w[k][31-8*j -: 8];
        return s;
    endfunction

    function automatic logic [31:0] s2w(input str_t s, input int k);
        return {s[4*k], s[4*k+1], s[4*k+2], s[4*k+3]};
    endfunction

    function automatic logic [31:0] exp_read(input int a);
        if (a == 0) return {28'b0, e_errt, e_errb, e_done, e_busy};
        if (a == 1) return {16'b0, s_len, 4'b0, s_index};
        if (a >= 2 && a < 2 + N) return sa[a-2];
        if (a >= 2 + N && a < 2 + 2*N) return sb[a-2-N];
        if (a >= 2 + 2*N && a < 2 + 3*N) return sr[a-2-2*N];
        return 32'h0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            sa[k] = '0; sb[k] = '0; sr[k] = '0;
        end
        s_index = '0; s_len = '0;
        e_busy = 0; e_done = 0; e_errb = 0; e_errt = 0;
    endtask

    task automatic model_write(input int a, input logic [31:0] d);
        if (a == 0) begin
            if (d[1]) begin e_done = 0; e_errb = 0; e_errt = 0; end
            if (d[0]) begin
                if (e_busy) e_errb = 1;
                else begin e_busy = 1; e_done = 0; end
            end
        end else if (a >= 1 && a < 2 + 2*N) begin
            if (e_busy) e_errb = 1;
            else if (a == 1) begin s_index = d[3:0]; s_len = d[15:8]; end
            else if (a < 2 + N) sa[a-2] = d;
            else sb[a-2-N] = d;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input int a, input logic [31:0] d);
        @(negedge clk);
        avs.address = 4'(a); avs.writedata = d; avs.chipselect = 1'b1; avs.write = 1'b1;
        @(negedge clk);
        avs.chipselect = 1'b0; avs.write = 1'b0;
        $display("WR addr=%0d data=%08h", a, d);
    endtask

    task automatic bus_read(input int a, output logic [31:0] d);
        @(negedge clk);
        avs.address = 4'(a); avs.chipselect = 1'b1; avs.read = 1'b1;
        @(negedge clk);
        avs.chipselect = 1'b0; avs.read = 1'b0;
        d = avs.readdata;
        $display("RD addr=%0d data=%08h", a, d);
    endtask

    task automatic csr_wr(input int a, input logic [31:0] d);
        bus_write(a, d);
        model_write(a, d);
    endtask

    task automatic rd_chk(input int a, input string name);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp_read(a));
    endtask

    task automatic chk_ports(input string name);
        for (int k = 0; k < N; k++) begin
            check({name, "_A"}, {A[4*k], A[4*k+1], A[4*k+2], A[4*k+3]}, sa[k]);
            check({name, "_B"}, {B[4*k], B[4*k+1], B[4*k+2], B[4*k+3]}, sb[k]);
        end
        check({name, "_index"}, {28'b0, index}, {28'b0, s_index});
        check({name, "_length"}, {24'b0, length}, {24'b0, s_len});
    endtask

    task automatic start_op();
        pending_res = op_result(s_index, s_len, w2s(sa), w2s(sb));
        csr_wr(0, 32'h1);
    endtask

    task automatic finish_op(input string name, input bit timed_out);
        logic [31:0] d;
        bit          idle;
        idle = 1'b0;
        d    = 32'h1;
        for (int k = 0; k < 60 && !idle; k++) begin
            bus_read(0, d);
            idle = !d[0];
        end
        check({name, "_idle"}, {31'b0, d[0]}, 32'h0);
        e_busy = 0;
        if (timed_out) e_errt = 1;
        else begin
            e_done = 1;
            for (int k = 0; k < N; k++) sr[k] = s2w(pending_res, k);
        end
        rd_chk(0, {name, "_ctrl"});
        for (int k = 0; k < N; k++) rd_chk(2 + 2*N + k, {name, "_res"});
    endtask

    typedef struct {
        int          addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vt [8];

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          cnt;
        int          a;
        logic [31:0] wd;

        reset = 1'b1;
        avs.address = '0; avs.writedata = '0; avs.chipselect = 1'b0;
        avs.write = 1'b0; avs.read = 1'b0;
        core_delay = 0; core_never = 0; force_done = 0; pre_res = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_go", {31'b0, go}, 32'h0);
        check("rst_readdata", avs.readdata, 32'h0);
        rd_chk(0, "rst_ctrl");
        for (int k = 0; k < N; k++) rd_chk(2 + k, "rst_a");

        vt[0] = '{1,  32'hFFFF_FFFF, 32'h0000_FF0F, "cfg_mask"};
        vt[1] = '{1,  32'h1234_5678, 32'h0000_5608, "cfg_fields"};
        vt[2] = '{2,  32'hDEAD_BEEF, 32'hDEAD_BEEF, "a0_rw"};
        vt[3] = '{5,  32'h0102_0304, 32'h0102_0304, "b1_rw"};
        vt[4] = '{6,  32'hFFFF_FFFF, 32'h0000_0000, "r0_ro"};
        vt[5] = '{8,  32'hCAFE_BABE, 32'h0000_0000, "unmapped8"};
        vt[6] = '{15, 32'h0000_0001, 32'h0000_0000, "unmapped15"};
        vt[7] = '{0,  32'h0000_0000, 32'h0000_0000, "ctrl_zero"};
        for (int i = 0; i < 8; i++) begin
            csr_wr(vt[i].addr, vt[i].wdata);
            bus_read(vt[i].addr, d);
            check(vt[i].name, d, vt[i].exp);
        end

        // Packing: "abcdefgh" on the core port, index=UPPER.
        csr_wr(2, 32'h6162_6364);
        csr_wr(3, 32'h6566_6768);
        csr_wr(1, 32'h0000_0001);
        chk_ports("pack");
        check("pack_a_byte0", {24'b0, A[0]}, 32'h61);
        check("pack_a_byte7", {24'b0, A[7]}, 32'h68);
        rd_chk(3, "a1_readback");

        core_delay = 2;
        start_op();
        check("upper_go", {31'b0, go}, 32'h1);
        rd_chk(0, "upper_busy");
        finish_op("upper", 0);
        bus_read(6, d);
        check("upper_r0", d, 32'h4142_4344);
        bus_read(7, d);
        check("upper_r1", d, 32'h4546_4748);

        // Writes and START while busy are dropped and flagged.
        core_delay = 0; core_never = 1;
        start_op();
        csr_wr(2, 32'h1111_1111);
        chk_ports("busywr");
        rd_chk(0, "busywr_ctrl");
        csr_wr(0, 32'h1);
        core_never = 0;
        finish_op("busywr", 0);
        csr_wr(0, 32'h2);
        rd_chk(0, "clr_ctrl");

        // Search "was" in "It was I".
        csr_wr(2, 32'h4974_2077);
        csr_wr(3, 32'h6173_2049);
        csr_wr(4, 32'h7761_7320);
        csr_wr(5, 32'h2020_2020);
        csr_wr(1, 32'h0000_0304);
        core_delay = 2;
        start_op();
        finish_op("search", 0);
        bus_read(6, d);
        check("search_r0", d, 32'h0);
        bus_read(7, d);
        check("search_r1", d, 32'h0000_0003);

        // Done already high at START: captured in the first RUN cycle.
        core_never = 1;
        pre_res = 64'h7A79_7877_7675_7473;
        force_done = 1;
        start_op();
        pending_res = pre_res;
        check("predone_go_run", {31'b0, go}, 32'h1);
        @(negedge clk);
        check("predone_go_drop", {31'b0, go}, 32'h0);
        force_done = 0;
        core_never = 0;
        finish_op("predone", 0);

        // CLR and START together: flags cleared, new op starts.
        start_op();
        model_write(0, 32'h2);
        e_busy = 1;
        rd_chk(0, "clrstart_ctrl");
        finish_op("clrstart", 0);
        csr_wr(0, 32'h3);
        rd_chk(0, "clrstart2_ctrl");
        finish_op("clrstart2", 0);

        // Reset mid-operation.
        core_never = 1;
        start_op();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_go", {31'b0, go}, 32'h0);
        model_reset();
        core_never = 0;
        rd_chk(0, "midrst_ctrl");
        rd_chk(6, "midrst_r0");
        rd_chk(7, "midrst_r1");
        rd_chk(2, "midrst_a0");

`ifdef STRING_HW_TIMEOUT_EN
        csr_wr(2, 32'h6162_6364);
        csr_wr(1, 32'h0000_0001);
        core_delay = 0;
        start_op();
        finish_op("pretmo", 0);
        core_never = 1;
        start_op();
        cnt = 0;
        while (go === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("tmo_run_cycles", 32'(cnt), 32'(TMO));
        finish_op("tmo", 1);
        core_never = 0;
        csr_wr(0, 32'h2);
        rd_chk(0, "tmo_clr");
`endif

        // Randomized idle register traffic.
        for (int t = 0; t < 60; t++) begin
            a  = $urandom_range(0, 15);
            wd = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                if (a == 0) wd = wd & 32'h2;
                csr_wr(a, wd);
            end else begin
                rd_chk(a, "rnd_rd");
            end
        end
        chk_ports("rnd_ports");

        // Randomized operations.
        for (int t = 0; t < 12; t++) begin
            for (int k = 0; k < N; k++) begin
                wd = {8'($urandom_range(97, 122)), 8'($urandom_range(65, 90)),
                      8'($urandom_range(97, 122)), 8'($urandom_range(97, 122))};
                csr_wr(2 + k, wd);
                wd = {8'($urandom_range(97, 122)), 8'($urandom_range(97, 122)),
                      8'($urandom_range(97, 122)), 8'($urandom_range(97, 122))};
                csr_wr(2 + N + k, wd);
            end
            if ($urandom_range(0, 1) == 1) csr_wr(2 + N, {sa[N-1][15:0], 16'h2020});
            wd = {16'b0, 8'($urandom_range(1, 3)), 4'b0, 4'($urandom_range(0, 4))};
            csr_wr(1, wd);
            core_delay = $urandom_range(0, 4);
            chk_ports("op_ports");
            start_op();
            finish_op("rnd_op", 0);
            csr_wr(0, 32'h2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/string_hw_csr.md
Name: string_hw_csr

Overview:
- Avalon-MM slave front-end placed directly upstream of the String_HW accelerator core.
- Accepts 32-bit register writes from the Nios II and packs them into the core's A/B string blocks, index and length.
- Runs the core's go/done handshake and captures Result into readable registers.
- Provides busy, done and error status so software can poll instead of relying on fixed delays.

Parameters:
- MAX_BLOCKS, 2, number of 32-bit words per string operand. Legal range 1..4; each operand is MAX_BLOCKS*4 bytes.
- ADDR_W, 4, Avalon word-address width.
- TIMEOUT_CYCLES, 1024, cycles allowed in RUN before abort. Used only with STRING_HW_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  ADDR_W  Avalon word address
- chipselect  in  1  slave select
- write  in  1  write strobe
- writedata  in  32  write data
- read  in  1  read strobe
- readdata  out  32  read data, registered
- go  out  1  level start to core
- index  out  4  operation select to core
- length  out  8  search length to core
- A  out  MAX_BLOCKS*4 x 8  operand A, packed [0:N-1][7:0]; byte 0 is the first character
- B  out  MAX_BLOCKS*4 x 8  operand B, same packing as A
- done  in  1  core completion
- Result  in  MAX_BLOCKS*4 x 8  core result, same packing as A

Behaviour:
- Interface: one clock (clk). reset is synchronous and active-high.
- Register map (word addresses; N = MAX_BLOCKS):
  - 0 CTRL.
    - Write: bit0 START, bit1 CLR (clears done and error flags).
    - Read: bit0 busy, bit1 done_flag, bit2 err_busy_write, bit3 err_timeout; bits 31:4 read 0.
  - 1 CFG: [3:0] index, [15:8] length. Readback returns the same fields; other bits read 0.
  - 2..2+N-1: A words, R/W.
  - 2+N..2+2N-1: B words, R/W.
  - 2+2N..2+3N-1: Result words, read-only.
  - Unmapped addresses: reads return 0, writes are ignored.
- Byte packing: word k holds string bytes 4k..4k+3. Byte 4k is at writedata[31:24]; byte 4k+3 is at [7:0]. This matches string-literal order.
- Reads: readdata is valid the cycle after chipselect&read (1-cycle latency), and holds otherwise.
- Reset values: all A/B/CFG/Result registers 0, go=0, readdata=0, flags=0, FSM in IDLE.
- FSM:
  - IDLE: go=0. START write moves to RUN; done_flag is cleared on entry to RUN.
  - RUN: go=1. When done=1, capture Result into the result registers in that same cycle and move to RELEASE.
  - RELEASE: go=0. When done=0, set done_flag and move to IDLE.
  - busy = (state != IDLE).
- Minimum start-to-done_flag latency is 3 cycles when the core answers immediately.
- Any write to CFG/A/B, or a START, while busy is ignored and sets err_busy_write (sticky until CLR or reset).
- START and CLR in the same write: CLR is applied first, then START.
- done already high when START arrives: capture in the first RUN cycle. No stale-done filtering; software must clear the core first.
- Reset mid-operation: go drops in the next cycle, FSM returns to IDLE, and captured Result is lost.
- Result registers change only on capture. They retain their last value across IDLE.

Optional Feature:
- STRING_HW_TIMEOUT_EN defined:
  - A cycle counter runs in RUN.
  - When it reaches TIMEOUT_CYCLES with done still 0, the FSM moves to RELEASE without capturing, sets err_timeout and leaves done_flag clear.
  - The counter resets on every entry to RUN.
- Undefined:
  - No counter is built; RUN waits indefinitely.
  - CTRL bit3 reads 0.

Decomposition:
- Package string_hw_pkg holds:
  - MAX_BLOCKS default
  - the string_t typedef (logic [0:MAX_BLOCKS*4-1][7:0])
  - address-offset localparams CTRL_ADDR, CFG_ADDR, A_BASE, B_BASE, R_BASE
  - the op-index enum (CMP=0, UPPER=1, LOWER=2, REVERSE=3, SEARCH=4)
  - the FSM state enum
- One natural sub-module, string_word_pack: converts between a 32-bit word with its word index and byte slots in string_t. It is instantiated for the A, B and Result paths.

Test Plan:
- Reset, then read CTRL and each A word → readdata=0 one cycle after read; go=0.
- Write A0=0x61626364 ("abcd"), A1=0x65666768, CFG index=1 → A=="abcdefgh", index=1 on core ports. Read A1 back → 0x65666768.
- START with a behavioural core model answering done 2 cycles after go, Result="ABCDEFGH" → go high for RUN, busy=1, done_flag=1 after release. Read R0 → 0x41424344.
- Write A0 while busy → A unchanged, CTRL bit2=1. Write CTRL=0x2 → bit2=0.
- Search: A="It was I", B="was     ", CFG index=4 length=3, START; model returns 3 → R words read 0 except R1[7:0]=3.
- With STRING_HW_TIMEOUT_EN and TIMEOUT_CYCLES=16, model never asserts done → go drops after 16 RUN cycles, bit3=1, bit1=0, Result registers unchanged.
